dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the data-cache request interface (D_req/D_addr/D_write/D_in/D_type in; D_out/D_wait out).
- Sits between the L1 data cache and a single-port word SRAM.
- Services single-word reads (including the cache's 4-word line-fill sequence) and byte/half/word write-throughs.
- Write data arrives unshifted; this block lane-aligns it and generates byte write enables.

Parameters:
- AW, 14, SRAM word-address width (depth 2^AW words).
- BASE_ADDR, 32'h0001_0000, byte base address of the SRAM window; must be aligned to 2^(AW+2).
- RD_LAT, 1, busy cycles per read, >=1.
- WR_LAT, 1, busy cycles per write, >=1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- D_req  in  1  request valid
- D_addr  in  32  byte address
- D_write  in  1  1=write, 0=read
- D_in  in  32  write data, unshifted (byte in [7:0], half in [15:0])
- D_type  in  3  000/100 byte, 001/101 half, 010 word; others invalid
- D_out  out  32  read data, registered, full aligned word
- D_wait  out  1  1=busy, request not accepted
- sram_cs  out  1  SRAM chip select
- sram_web  out  4  per-byte write enable, active low (1111=read)
- sram_addr  out  AW  SRAM word address
- sram_di  out  32  SRAM write data
- sram_do  in  32  SRAM read data, valid the cycle after a read access
- err  out  1  one-cycle pulse on a rejected access

Behaviour:
- Reset (rst=0, async): state=IDLE, D_out=0, D_wait=0, err=0, busy counter=0, sram_cs=0, sram_web=1111. Reset mid-transaction aborts it; no SRAM write is issued after reset assertion.
- Handshake: in IDLE, D_wait=0 combinationally. A request is accepted at the rising edge where D_req=1 and state=IDLE. In BUSY, D_wait=1.
- D_out: changes only on read completion. Held through writes and idle until the next read completes. The cache samples it when D_wait drops.
- In-range: D_addr[31:AW+2]==BASE_ADDR[31:AW+2]. sram_addr=D_addr[AW+1:2].
- FSM states: IDLE, RD_BUSY, WR_BUSY.
- IDLE, D_req=1, D_write=0:
  - Cycle of acceptance drives sram_cs=1, sram_web=1111; latch request.
  - Next state RD_BUSY, cnt=RD_LAT-1.
- RD_BUSY:
  - First cycle: D_out<=sram_do, or 0 if out of range.
  - cnt decrements each cycle; at cnt==0 go to IDLE.
  - RD_LAT=1 timing: accept at edge T, D_wait=1 for cycle T+1, D_out valid and D_wait=0 from T+2.
- IDLE, D_req=1, D_write=1:
  - Same cycle drives sram_cs=1, sram_di=lane-shifted data, sram_web per the write table below.
  - Next state WR_BUSY for WR_LAT cycles, then IDLE.
- Write table (byte lane = D_addr[1:0]):
  - byte: data={4{D_in[7:0]}}; web clears the addressed lane bit (e.g. 01 -> 1101).
  - half, addr[1:0]=00: web=1100, data={2{D_in[15:0]}}.
  - half, addr[1:0]=10: web=0011, same data.
  - word, addr[1:0]=00: web=0000, data=D_in.
- Rejected access (err pulses 1 cycle, during the first BUSY cycle):
  - Covers misaligned half/word, invalid D_type, or out of range.
  - Rejected write: sram_web=1111, no write.
  - Read misalignment/type is ignored: the aligned word is returned. Only out-of-range reads return 0 and raise err.
- D_req dropping or the address changing during BUSY: ignored; the latched transaction completes. A D_req still high on return to IDLE is accepted as a new request (back-to-back, one IDLE cycle minimum).
- Outside the accept cycle: sram_cs=0, sram_web=1111.
- Line fill: four sequential reads addr+0,4,8,C. Each D_out is valid when D_wait drops for the next request. The 4th word is held until a later read.

Test Plan:
- Reset then idle: rst=0 mid-RD_BUSY -> D_out=0, D_wait=0, sram_web=1111 immediately; no write seen after release.
- Word write/read: write 32'hDEADBEEF to 0x0001_0010 (type 010), then read -> sram_web=0000 at sram_addr=4; read D_out=32'hDEADBEEF at T+2, D_wait high exactly 1 cycle.
- Byte/half lanes:
  - Byte 8'hA5 to 0x0001_0013 -> web=0111, di=32'hA5A5A5A5.
  - Half 16'h1234 to 0x0001_0012 -> web=0011.
  - Read back the word (prior 32'h0) -> 32'hA5340000 after the sequence: half 1234 at bytes 2-3, then byte A5 overwriting byte 3. Byte is written after the half.
- Line fill: preload words 0x11,0x22,0x33,0x44 at 0x0001_0040..4C; hold D_req=1 with addresses advancing on each D_wait=0 -> D_out sequence 0x11,0x22,0x33,0x44, one word per 2 cycles (RD_LAT=1).
- Errors:
  - Half write to 0x0001_0011 -> err=1, web stays 1111, memory unchanged.
  - Read 0x2000_0000 -> D_out=0, err=1.
- RD_LAT=3, WR_LAT=2 build: D_wait high 3 cycles per read and 2 per write; D_req deasserted mid-busy still completes the write.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder between the L1 data cache request
// interface and a single-port word SRAM. Reads return the full aligned word;
// writes are lane-aligned here and turned into active-low byte enables.
module dmem_responder #(
  parameter int          AW        = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          RD_LAT    = 1,
  parameter int          WR_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          D_req,
  input  logic [31:0]   D_addr,
  input  logic          D_write,
  input  logic [31:0]   D_in,
  input  logic [2:0]    D_type,
  output logic [31:0]   D_out,
  output logic          D_wait,
  output logic          sram_cs,
  output logic [3:0]    sram_web,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_di,
  input  logic [31:0]   sram_do,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          first_reg, first_next;   // marks the first busy cycle
  logic          rd_ok_reg, rd_ok_next;   // latched in-range flag of a read
  logic [31:0]   d_out_reg, d_out_next;
  logic          err_reg, err_next;

  logic          in_range;
  logic          is_byte, is_half, is_word;
  logic          aligned, wr_ok;
  logic          accept;
  logic [3:0]    lane_en;

  // Request decode, purely from the live request inputs (accept cycle only).
  assign in_range = (D_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign is_byte  = (D_type == 3'b000) || (D_type == 3'b100);
  assign is_half  = (D_type == 3'b001) || (D_type == 3'b101);
  assign is_word  = (D_type == 3'b010);
  assign aligned  = is_byte || (is_half && !D_addr[0]) ||
                    (is_word && (D_addr[1:0] == 2'b00));
  assign wr_ok    = in_range && aligned;

  // Reset gates acceptance so nothing reaches the SRAM while rst is low.
  assign accept    = rst && (state_reg == IDLE) && D_req;
  assign sram_addr = D_addr[AW+1:2];

  // Per-lane enable and write data replication (byte x4, half x2, word as-is).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_en[gi] = is_word ||
                           (is_half && (D_addr[1] == LANE[1])) ||
                           (is_byte && (D_addr[1:0] == LANE));
      assign sram_di[8*gi +: 8] = is_byte ? D_in[7:0] :
                                  is_half ? D_in[8*(gi%2) +: 8] :
                                            D_in[8*gi +: 8];
    end
  endgenerate

  // Next-state and SRAM strobe logic; strobes only exist in the accept cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    first_next = 1'b0;
    rd_ok_next = rd_ok_reg;
    d_out_next = d_out_reg;
    err_next   = 1'b0;
    sram_cs    = 1'b0;
    sram_web   = 4'hF;
    D_wait     = 1'b1;
    case (state_reg)
      IDLE: begin
        D_wait = 1'b0;
        if (accept) begin
          sram_cs    = 1'b1;
          first_next = 1'b1;
          if (D_write) begin
            if (wr_ok) sram_web = ~lane_en;
            err_next   = !wr_ok;
            state_next = WR_BUSY;
            cnt_next   = CW'(WR_LAT - 1);
          end else begin
            // Read misalignment and type are ignored; only range matters.
            rd_ok_next = in_range;
            err_next   = !in_range;
            state_next = RD_BUSY;
            cnt_next   = CW'(RD_LAT - 1);
          end
        end
      end
      RD_BUSY: begin
        if (first_reg) d_out_next = rd_ok_reg ? sram_do : 32'h0;
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      WR_BUSY: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      first_reg <= 1'b0;
      rd_ok_reg <= 1'b0;
      d_out_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      first_reg <= first_next;
      rd_ok_reg <= rd_ok_next;
      d_out_reg <= d_out_next;
      err_reg   <= err_next;
    end
  end

  assign D_out = d_out_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances share the request inputs, one
// with unit latencies (dut_a) and one with RD_LAT=3/WR_LAT=2 (dut_b), each
// backed by its own behavioural SRAM with registered read.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          D_req, D_write;
  logic [31:0]   D_addr, D_in;
  logic [2:0]    D_type;
  logic [31:0]   d_out_a, d_out_b, di_a, di_b, do_a, do_b;
  logic          d_wait_a, d_wait_b, cs_a, cs_b, err_a, err_b;
  logic [3:0]    web_a, web_b;
  logic [AW-1:0] addr_a, addr_b;

  logic [31:0]   mem_a [0:(1<<AW)-1];
  logic [31:0]   mem_b [0:(1<<AW)-1];
  int            wr_cnt_a = 0;

  int errors = 0;
  int checks = 0;

  // Per-access observations.
  int            ba, bb;
  logic          ea, eb, cs_s;
  logic [3:0]    w_s;
  logic [31:0]   di_s;
  logic [AW-1:0] ad_s;

  dmem_responder #(.AW(AW), .BASE_ADDR(32'h0001_0000), .RD_LAT(1), .WR_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .D_req(D_req), .D_addr(D_addr), .D_write(D_write),
    .D_in(D_in), .D_type(D_type), .D_out(d_out_a), .D_wait(d_wait_a),
    .sram_cs(cs_a), .sram_web(web_a), .sram_addr(addr_a), .sram_di(di_a),
    .sram_do(do_a), .err(err_a)
  );

  dmem_responder #(.AW(AW), .BASE_ADDR(32'h0001_0000), .RD_LAT(3), .WR_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .D_req(D_req), .D_addr(D_addr), .D_write(D_write),
    .D_in(D_in), .D_type(D_type), .D_out(d_out_b), .D_wait(d_wait_b),
    .sram_cs(cs_b), .sram_web(web_b), .sram_addr(addr_b), .sram_di(di_b),
    .sram_do(do_b), .err(err_b)
  );

  // SRAM model for dut_a: byte-masked write, read-before-write registered read.
  always @(posedge clk) begin
    if (cs_a) begin
      for (int i = 0; i < 4; i++)
        if (!web_a[i]) mem_a[addr_a][8*i +: 8] <= di_a[8*i +: 8];
      do_a <= mem_a[addr_a];
    end
  end

  // SRAM model for dut_b.
  always @(posedge clk) begin
    if (cs_b) begin
      for (int j = 0; j < 4; j++)
        if (!web_b[j]) mem_b[addr_b][8*j +: 8] <= di_b[8*j +: 8];
      do_b <= mem_b[addr_b];
    end
  end

  // Count real write strobes seen by dut_a's SRAM.
  always @(posedge clk) begin
    if (cs_a && (web_a != 4'hF)) wr_cnt_a <= wr_cnt_a + 1;
  end

  // One access: present at a negedge, capture strobes, drop request and
  // scramble the address during busy, then wait until both DUTs are idle.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] t);
    int n;
    D_req = 1'b1; D_write = wr; D_addr = a; D_in = d; D_type = t;
    #1;
    cs_s = cs_a; w_s = web_a; di_s = di_a; ad_s = addr_a;
    @(negedge clk);
    D_req = 1'b0; D_addr = 32'hFFFF_FFFC; D_in = ~d;
    ba = 0; bb = 0; ea = 1'b0; eb = 1'b0; n = 0;
    while ((d_wait_a || d_wait_b) && n < 20) begin
      if (n == 0) begin ea = err_a; eb = err_b; end
      if (d_wait_a) ba++;
      if (d_wait_b) bb++;
      n++;
      @(negedge clk);
    end
    $display("txn %s addr=%h data=%h type=%b web=%b busy=%0d/%0d err=%b/%b dout=%h/%h",
             wr ? "WR" : "RD", a, d, t, w_s, ba, bb, ea, eb, d_out_a, d_out_b);
  endtask

  task automatic test_reset();
    rst = 1'b0; D_req = 1'b0; D_write = 1'b0; D_addr = 32'h0; D_in = 32'h0; D_type = 3'b010;
    @(negedge clk); @(negedge clk);
    checks++; if (d_wait_a !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", d_wait_a); end
    checks++; if (d_out_a !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 00000000", d_out_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_a); end
    checks++; if (cs_a !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", cs_a); end
    checks++; if (web_a !== 4'hF) begin errors++; $display("FAIL reset_web: got %b want 1111", web_a); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    access(1'b1, 32'h0001_0010, 32'hDEADBEEF, 3'b010);
    checks++; if (cs_s !== 1'b1) begin errors++; $display("FAIL word_wr_cs: got %b want 1", cs_s); end
    checks++; if (w_s !== 4'b0000) begin errors++; $display("FAIL word_wr_web: got %b want 0000", w_s); end
    checks++; if (ad_s !== 14'd4) begin errors++; $display("FAIL word_wr_addr: got %0d want 4", ad_s); end
    checks++; if (di_s !== 32'hDEADBEEF) begin errors++; $display("FAIL word_wr_di: got %h want deadbeef", di_s); end
    checks++; if (ba !== 1) begin errors++; $display("FAIL word_wr_busy: got %0d want 1", ba); end
    checks++; if (ea !== 1'b0) begin errors++; $display("FAIL word_wr_err: got %b want 0", ea); end
    access(1'b0, 32'h0001_0010, 32'h0, 3'b010);
    checks++; if (w_s !== 4'hF) begin errors++; $display("FAIL word_rd_web: got %b want 1111", w_s); end
    checks++; if (ba !== 1) begin errors++; $display("FAIL word_rd_busy: got %0d want 1", ba); end
    checks++; if (d_out_a !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd_dout: got %h want deadbeef", d_out_a); end
  endtask

  task automatic test_lanes();
    access(1'b1, 32'h0001_0010, 32'h0, 3'b010);
    access(1'b1, 32'h0001_0012, 32'h0000_1234, 3'b001);
    checks++; if (w_s !== 4'b0011) begin errors++; $display("FAIL half_web: got %b want 0011", w_s); end
    checks++; if (di_s !== 32'h1234_1234) begin errors++; $display("FAIL half_di: got %h want 12341234", di_s); end
    access(1'b1, 32'h0001_0013, 32'h0000_00A5, 3'b000);
    checks++; if (w_s !== 4'b0111) begin errors++; $display("FAIL byte_web: got %b want 0111", w_s); end
    checks++; if (di_s !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byte_di: got %h want a5a5a5a5", di_s); end
    access(1'b1, 32'h0001_0015, 32'h0000_00C3, 3'b100);
    checks++; if (w_s !== 4'b1101) begin errors++; $display("FAIL byte100_web: got %b want 1101", w_s); end
    checks++; if (di_s !== 32'hC3C3_C3C3) begin errors++; $display("FAIL byte100_di: got %h want c3c3c3c3", di_s); end
    access(1'b0, 32'h0001_0010, 32'h0, 3'b010);
    checks++; if (d_out_a !== 32'hA534_0000) begin errors++; $display("FAIL lanes_rd_a: got %h want a5340000", d_out_a); end
    checks++; if (d_out_b !== 32'hA534_0000) begin errors++; $display("FAIL lanes_rd_b: got %h want a5340000", d_out_b); end
  endtask

  task automatic test_line_fill();
    logic [31:0] got [4];
    logic [31:0] exp_w [4];
    int k, cyc, n;
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
    for (int i = 0; i < 4; i++) access(1'b1, 32'h0001_0040 + 32'(4*i), exp_w[i], 3'b010);
    for (int i = 0; i < 4; i++) got[i] = 32'h0;
    D_req = 1'b1; D_write = 1'b0; D_type = 3'b010; D_addr = 32'h0001_0040;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!d_wait_a) begin
        got[k] = d_out_a;
        $display("txn FILL word=%0d dout=%h cycle=%0d", k, d_out_a, cyc);
        k++;
        if (k == 4) D_req = 1'b0;
        else        D_addr = D_addr + 32'd4;
      end
    end
    D_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin errors++; $display("FAIL fill_word%0d: got %h want %h", i, got[i], exp_w[i]); end
    end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL fill_cycles: got %0d want 8", cyc); end
    n = 0;
    while (d_wait_b && n < 20) begin n++; @(negedge clk); end
    repeat (2) @(negedge clk);
    checks++; if (d_out_a !== 32'h44) begin errors++; $display("FAIL fill_hold: got %h want 00000044", d_out_a); end
  endtask

  task automatic test_errors();
    int wc;
    wc = wr_cnt_a;
    access(1'b1, 32'h0001_0011, 32'h0000_BEEF, 3'b001);
    checks++; if (ea !== 1'b1) begin errors++; $display("FAIL mis_half_err: got %b want 1", ea); end
    checks++; if (eb !== 1'b1) begin errors++; $display("FAIL mis_half_err_b: got %b want 1", eb); end
    checks++; if (w_s !== 4'hF) begin errors++; $display("FAIL mis_half_web: got %b want 1111", w_s); end
    checks++; if (wr_cnt_a !== wc) begin errors++; $display("FAIL mis_half_nowrite: got %0d want %0d", wr_cnt_a, wc); end
    access(1'b1, 32'h0001_0010, 32'h5555_5555, 3'b011);
    checks++; if (ea !== 1'b1) begin errors++; $display("FAIL bad_type_err: got %b want 1", ea); end
    checks++; if (w_s !== 4'hF) begin errors++; $display("FAIL bad_type_web: got %b want 1111", w_s); end
    access(1'b1, 32'h3001_0010, 32'h6666_6666, 3'b010);
    checks++; if (ea !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", ea); end
    checks++; if (w_s !== 4'hF) begin errors++; $display("FAIL oor_wr_web: got %b want 1111", w_s); end
    access(1'b0, 32'h0001_0012, 32'h0, 3'b010);
    checks++; if (d_out_a !== 32'hA534_0000) begin errors++; $display("FAIL unchanged_rd: got %h want a5340000", d_out_a); end
    checks++; if (ea !== 1'b0) begin errors++; $display("FAIL mis_rd_err: got %b want 0", ea); end
    access(1'b0, 32'h2000_0000, 32'h0, 3'b010);
    checks++; if (d_out_a !== 32'h0) begin errors++; $display("FAIL oor_rd_dout: got %h want 00000000", d_out_a); end
    checks++; if (ea !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", ea); end
    checks++; if (d_out_b !== 32'h0) begin errors++; $display("FAIL oor_rd_dout_b: got %h want 00000000", d_out_b); end
  endtask

  task automatic test_reset_abort();
    int wc;
    access(1'b0, 32'h0001_0010, 32'h0, 3'b010);
    D_req = 1'b1; D_write = 1'b0; D_addr = 32'h0001_0010; D_type = 3'b010;
    @(negedge clk);
    rst = 1'b0; D_write = 1'b1; D_in = 32'h5555_5555;
    #1;
    wc = wr_cnt_a;
    $display("txn RESET during busy dout=%h wait=%b", d_out_a, d_wait_a);
    checks++; if (d_wait_a !== 1'b0) begin errors++; $display("FAIL abort_wait: got %b want 0", d_wait_a); end
    checks++; if (d_out_a !== 32'h0) begin errors++; $display("FAIL abort_dout: got %h want 00000000", d_out_a); end
    checks++; if (web_a !== 4'hF) begin errors++; $display("FAIL abort_web: got %b want 1111", web_a); end
    checks++; if (cs_a !== 1'b0) begin errors++; $display("FAIL abort_cs: got %b want 0", cs_a); end
    checks++; if (d_wait_b !== 1'b0) begin errors++; $display("FAIL abort_wait_b: got %b want 0", d_wait_b); end
    @(negedge clk); @(negedge clk);
    D_req = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_cnt_a !== wc) begin errors++; $display("FAIL abort_nowrite: got %0d want %0d", wr_cnt_a, wc); end
    access(1'b0, 32'h0001_0010, 32'h0, 3'b010);
    checks++; if (d_out_a !== 32'hA534_0000) begin errors++; $display("FAIL abort_mem: got %h want a5340000", d_out_a); end
  endtask

  task automatic test_latency();
    access(1'b1, 32'h0001_0020, 32'hCAFE_F00D, 3'b010);
    checks++; if (bb !== 2) begin errors++; $display("FAIL lat_wr_busy_b: got %0d want 2", bb); end
    checks++; if (ba !== 1) begin errors++; $display("FAIL lat_wr_busy_a: got %0d want 1", ba); end
    access(1'b0, 32'h0001_0020, 32'h0, 3'b010);
    checks++; if (bb !== 3) begin errors++; $display("FAIL lat_rd_busy_b: got %0d want 3", bb); end
    checks++; if (d_out_b !== 32'hCAFE_F00D) begin errors++; $display("FAIL lat_rd_dout_b: got %h want cafef00d", d_out_b); end
    checks++; if (d_out_a !== 32'hCAFE_F00D) begin errors++; $display("FAIL lat_rd_dout_a: got %h want cafef00d", d_out_a); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_line_fill();
    test_errors();
    test_reset_abort();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
